// File: rtl/seq_mag_comparator_pkg.sv
// -----------------------------------------------------------------------------
// seq_cmp_pkg
// Shared definitions for the sequential magnitude comparator:
//   - state_t : controller state encoding (IDLE, RUN, DONE), 2 bits
//   - G0/L0/E0: carry values loaded at the start of every comparison
//   - SLICE_W : width of the shared cascade slice (one nibble)
// -----------------------------------------------------------------------------
package seq_cmp_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // An empty prefix (no nibbles seen yet) compares as "equal".
  localparam logic G0 = 1'b0;
  localparam logic L0 = 1'b0;
  localparam logic E0 = 1'b1;

endpackage

// File: rtl/seq_mag_comparator_if.sv
// -----------------------------------------------------------------------------
// seq_mag_comparator_if
// Start/done handshake and operand/result bundle of the sequential comparator.
//   start, abort : request / cancel from the requesting datapath
//   a, b         : WIDTH-bit operands, sampled when a start is accepted
//   ready, busy  : controller status (IDLE / RUN)
//   done         : one-cycle pulse, gt/lt/eq valid
//   gt, lt, eq   : held comparison result
// Modports: master = requester, slave = comparator.
// -----------------------------------------------------------------------------
interface seq_mag_comparator_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic             abort;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic             gt;
  logic             lt;
  logic             eq;

  modport master (
    output start, abort, a, b,
    input  ready, busy, done, gt, lt, eq
  );

  modport slave (
    input  start, abort, a, b,
    output ready, busy, done, gt, lt, eq
  );

endinterface

// File: rtl/seq_mag_comparator_cmp_slice4.sv
// -----------------------------------------------------------------------------
// cmp_slice4
// Purely combinational 4-bit cascade comparator slice. Combines the ordering
// of one nibble with the carry from the less significant nibbles: a nibble
// that differs decides, an equal nibble passes the incoming carry through.
//   x, y            : nibble of operand A / B
//   g_in, l_in, e_in: carry from lower nibbles
//   g, l, e         : carry including this nibble
// -----------------------------------------------------------------------------
module cmp_slice4
  import seq_cmp_pkg::*;
(
  input  logic [SLICE_W-1:0] x,
  input  logic [SLICE_W-1:0] y,
  input  logic               g_in,
  input  logic               l_in,
  input  logic               e_in,
  output logic               g,
  output logic               l,
  output logic               e
);

  logic nib_eq;

  assign nib_eq = (x == y);
  assign g      = (x > y) | (nib_eq & g_in);
  assign l      = (x < y) | (nib_eq & l_in);
  assign e      = nib_eq & e_in;

endmodule

// File: rtl/seq_mag_comparator.sv
// -----------------------------------------------------------------------------
// seq_mag_comparator
// Multi-cycle magnitude comparator: one shared cmp_slice4 is stepped over the
// operand nibbles, LSB nibble first, with the G/L/E carry held in registers.
// A comparison takes NIBBLES RUN cycles followed by one DONE cycle.
//
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : seq_mag_comparator_if.slave (start/abort/a/b in,
//         ready/busy/done/gt/lt/eq out)
//
// Parameters:
//   WIDTH : operand width, multiple of 4 and >= 8
//
// Build option:
//   SEQ_CMP_SIGNED_EN : when defined, operands are two's complement; differing
//                       sign bits override the unsigned result at completion.
// -----------------------------------------------------------------------------
module seq_mag_comparator
  import seq_cmp_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_mag_comparator_if.slave  bus
);

  localparam int NIBBLES = WIDTH / SLICE_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic             g_reg, g_next;
  logic             l_reg, l_next;
  logic             e_reg, e_next;
  logic             gt_reg, gt_next;
  logic             lt_reg, lt_next;
  logic             eq_reg, eq_next;

  // Nibble views of the operand registers; the current one is picked by index.
  logic [SLICE_W-1:0] a_nib [NIBBLES];
  logic [SLICE_W-1:0] b_nib [NIBBLES];

  genvar gi;
  generate
    for (gi = 0; gi < NIBBLES; gi++) begin : g_nib
      assign a_nib[gi] = a_reg[gi*SLICE_W +: SLICE_W];
      assign b_nib[gi] = b_reg[gi*SLICE_W +: SLICE_W];
    end
  endgenerate

  logic [SLICE_W-1:0] a_cur, b_cur;
  logic               g_out, l_out, e_out;

  assign a_cur = a_nib[idx_reg];
  assign b_cur = b_nib[idx_reg];

  cmp_slice4 u_slice (
    .x    (a_cur),
    .y    (b_cur),
    .g_in (g_reg),
    .l_in (l_reg),
    .e_in (e_reg),
    .g    (g_out),
    .l    (l_out),
    .e    (e_out)
  );

  // Next-state and datapath update.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    g_next     = g_reg;
    l_next     = l_reg;
    e_next     = e_reg;
    gt_next    = gt_reg;
    lt_next    = lt_reg;
    eq_next    = eq_reg;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          a_next     = bus.a;
          b_next     = bus.b;
          g_next     = G0;
          l_next     = L0;
          e_next     = E0;
          idx_next   = '0;
          state_next = RUN;
        end
      end

      RUN: begin
        if (bus.abort) begin
          // Cancel: partial carry is thrown away, held result untouched.
          g_next     = G0;
          l_next     = L0;
          e_next     = E0;
          idx_next   = '0;
          state_next = IDLE;
        end else begin
          g_next = g_out;
          l_next = l_out;
          e_next = e_out;
          if (idx_reg == IDX_LAST) begin
            // Index wraps to 0 here instead of stepping past the last nibble,
            // so the nibble mux never sees an out-of-range select.
            idx_next   = '0;
            state_next = DONE;
            gt_next    = g_out;
            lt_next    = l_out;
            eq_next    = e_out;
`ifdef SEQ_CMP_SIGNED_EN
            // Different signs: the negative operand is the smaller one
            // regardless of the unsigned magnitude of the remaining bits.
            if (a_reg[WIDTH-1] != b_reg[WIDTH-1]) begin
              gt_next = b_reg[WIDTH-1];
              lt_next = a_reg[WIDTH-1];
            end
`endif
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      g_reg     <= G0;
      l_reg     <= L0;
      e_reg     <= E0;
      gt_reg    <= 1'b0;
      lt_reg    <= 1'b0;
      eq_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      g_reg     <= g_next;
      l_reg     <= l_next;
      e_reg     <= e_next;
      gt_reg    <= gt_next;
      lt_reg    <= lt_next;
      eq_reg    <= eq_next;
    end
  end

  // Operand registers carry no reset: they are only read after an accept.
  always_ff @(posedge clk) begin
    a_reg <= a_next;
    b_reg <= b_next;
  end

  assign bus.ready = (state_reg == IDLE);
  assign bus.busy  = (state_reg == RUN);
  assign bus.done  = (state_reg == DONE);
  assign bus.gt    = gt_reg;
  assign bus.lt    = lt_reg;
  assign bus.eq    = eq_reg;

endmodule

// File: doc/seq_mag_comparator.md
Name: seq_mag_comparator

Overview:
- Multi-cycle magnitude comparator controller for WIDTH-bit operands.
- Sequences one shared 4-bit cascade comparator slice over the operand nibbles, LSB nibble first.
- The greater/less/equal carry is held in registers between cycles.
- Sits beside the combinational comparators as an area-reduced alternative for wide operands; start/done handshake toward the requesting datapath.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of 4 and at least 8.
- NIBBLES, WIDTH/4, derived; number of slice iterations; not overridden by users.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only when ready=1.
- abort  input  1  cancels an operation in RUN.
- a  input  WIDTH  operand A; sampled on the accept edge.
- b  input  WIDTH  operand B; sampled on the accept edge.
- ready  output  1  high in IDLE only.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse when the result is valid.
- gt  output  1  A > B result.
- lt  output  1  A < B result.
- eq  output  1  A == B result.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- States: IDLE, RUN, DONE; 2-bit encoding.
- Reset, at the rising clk edge with rst=1:
  - state=IDLE; index=0; carry G=0, L=0, E=1.
  - gt=lt=eq=0; done=0; busy=0; ready=1.
  - Operand registers are don't-care.
- IDLE:
  - start=1 latches a and b into operand registers, sets carry G=0/L=0/E=1 and index=0, then goes to RUN.
  - start=0 stays in IDLE.
  - abort is ignored in IDLE.
- RUN, one nibble per cycle (n = operand[4*index+3 : 4*index]):
  - G <= (An>Bn) | ((An==Bn) & G).
  - L <= (An<Bn) | ((An==Bn) & L).
  - E <= (An==Bn) & E.
  - index increments each cycle.
  - After the index=NIBBLES-1 update, go to DONE.
- Precedence in RUN: abort=1 overrides the nibble step. Go to IDLE; no done pulse; gt/lt/eq keep their previous values; carry is discarded.
- start while RUN or DONE is ignored and not queued.
- DONE, one cycle:
  - gt/lt/eq are loaded from the final carry on the RUN->DONE edge, so they are valid when done=1.
  - done=1 for exactly this cycle, then IDLE.
- Latency: start accepted at edge k; done is high during the cycle after edge k+NIBBLES.
  - This gives NIBBLES+1 cycles from accept to done (9 for WIDTH=32).
  - Next accept is possible one cycle after done.
- Result hold: gt/lt/eq persist until the next completed operation or rst. Exactly one of gt/lt/eq is high after any completion.
- rst mid-RUN or mid-DONE: returns to the reset values above on that edge; no done pulse.
- Operand changes after acceptance have no effect.

Optional Feature:
- Macro: SEQ_CMP_SIGNED_EN.
- Defined: operands are two's complement. When a[WIDTH-1] != b[WIDTH-1], the DONE-load forces gt=b[WIDTH-1] and lt=a[WIDTH-1], overriding the unsigned carry. eq is unchanged.
- Undefined: pure unsigned comparison; no sign logic is synthesized.

Decomposition:
- Package seq_cmp_pkg holds:
  - state encoding constants (IDLE, RUN, DONE);
  - carry init constants (G0=0, L0=0, E0=1);
  - the SLICE_W=4 constant.
- One sub-module, cmp_slice4: purely combinational 4-bit cascade slice.
  - Inputs: 4-bit x/y plus g_in/l_in/e_in.
  - Outputs: g/l/e, per the RUN equations.
  - Instantiated once.

Test Plan:
- WIDTH=32, A=0x12345678, B=0x12345677, start -> done at cycle 9 after accept, gt=1 lt=0 eq=0; busy high for 8 cycles.
- A=B=0xDEADBEEF -> eq=1 gt=0 lt=0; then A=0x00000000, B=0xFFFFFFFF -> lt=1; results hold between ops.
- MSB nibble decides over LSB: A=0x20000000, B=0x1FFFFFFF -> gt=1 (checks LSB-first carry override).
- abort asserted in the 3rd RUN cycle -> IDLE next cycle, no done pulse, gt/lt/eq unchanged from the prior op; start during RUN ignored.
- rst during RUN -> all outputs return to reset values, ready=1; the next start completes normally.
- SEQ_CMP_SIGNED_EN defined: A=0xFFFFFFFF (-1), B=0x00000001 -> lt=1; undefined -> gt=1.
